move_input_sequencer: RTL

//   Input stage directly upstream of the character controller. Synchronises and debounces the

---
 rtl/move_input_sequencer_pkg.sv | 15 +
 rtl/move_input_sequencer_btn_debounce.sv | 43 ++++
 rtl/move_input_sequencer.sv | 78 +++++++
 3 files changed

// File: rtl/move_input_sequencer_pkg.sv
// Shared direction encoding and button indexing for the movement input path.
// The character controller and the ghost logic use the same direction codes.
package move_input_sequencer_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_e;

   // Buttons are indexed by their direction code, so a lower index means a higher priority (W > S > A > D).
   localparam int NUM_BTNS = 4;

endpackage

// File: rtl/move_input_sequencer_btn_debounce.sv
// One raw active-low button: two-flop synchroniser, stable-count debouncer and
// a one-cycle strobe that fires in the first cycle the debounced level reads low.
module btn_debounce
   import move_input_sequencer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1, sync2, level;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            // DEBOUNCE_CYCLES consecutive disagreeing samples: accept the new level.
            level <= sync2;
            cnt   <= '0;
            press <= ~sync2;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/move_input_sequencer.sv
// Button front end for the character controller: debounces W/A/S/D, latches the
// last pressed direction and emits one active-low move pulse per movement tick.
module move_input_sequencer
   import move_input_sequencer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int MOVE_PERIOD     = 2500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_w,
   input  logic       btn_a,
   input  logic       btn_s,
   input  logic       btn_d,
   input  logic       pause,
   output logic       move_w,
   output logic       move_a,
   output logic       move_s,
   output logic       move_d,
   output logic [1:0] dir,
   output logic       dir_valid
);

   localparam int TW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;

   logic [NUM_BTNS-1:0] raw, press, move_n;
   logic [TW-1:0]       tick_cnt;
   logic                tick, press_any;
   logic [1:0]          new_dir, pulse_dir;

   assign raw = {btn_d, btn_a, btn_s, btn_w};

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk   (clk),
         .reset (reset),
         .btn   (raw[i]),
         .press (press[i])
      );
   end

   // Lowest index wins; losing simultaneous presses are dropped.
   always_comb begin
      new_dir = DIR_RIGHT;
      for (int i = NUM_BTNS - 1; i >= 0; i--)
         if (press[i]) new_dir = 2'(i);
   end

   assign press_any = |press;
   assign tick      = !pause && (tick_cnt == TW'(MOVE_PERIOD - 1));
   // A press landing on the tick steers that very pulse.
   assign pulse_dir = press_any ? new_dir : dir;

   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt  <= '0;
         dir       <= DIR_UP;
         dir_valid <= 1'b0;
         move_n    <= '1;
      end else begin
         if (!pause)
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
         if (press_any) begin
            dir       <= new_dir;
            dir_valid <= 1'b1;
         end
         move_n <= '1;
         if (tick && (dir_valid || press_any))
            move_n[pulse_dir] <= 1'b0;
      end
   end

   assign move_w = move_n[DIR_UP];
   assign move_s = move_n[DIR_DOWN];
   assign move_a = move_n[DIR_LEFT];
   assign move_d = move_n[DIR_RIGHT];

endmodule
